// File: rtl/leaf_out_packetizer.sv
// Leaf output stage: one holding word per user port, credit-gated round-robin
// arbitration, and a registered BFT packet carrying destination and sequence.
module leaf_out_packetizer #(
  parameter int NUM_OUT_PORTS = 6,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49,
  parameter int CREDIT_BITS   = 7,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_sel,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic [NUM_OUT_PORTS-1:0]              credit_ret,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

  localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PTR_W     = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [PAYLOAD_BITS-1:0]  hold_p0 [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] full_p0;
  logic [NUM_ADDR_BITS-1:0] seq [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit [NUM_OUT_PORTS];
  logic [DEST_BITS-1:0]     dest [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_ptr;
  logic [PACKET_BITS-1:0]   pkt_p1;

  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [NUM_OUT_PORTS-1:0] capture;
  logic                     gnt_vld;
  logic [PTR_W-1:0]         gnt_idx;
  logic [PTR_W-1:0]         rr_next;
  logic [PTR_W:0]           sum;
  logic [PTR_W-1:0]         idx;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      elig[i] = full_p0[i] & (credit[i] != '0) & ~resend;
  end

  // First eligible port at or after the round-robin pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_OUT_PORTS))
        idx = PTR_W'(sum - (PTR_W+1)'(NUM_OUT_PORTS));
      else
        idx = PTR_W'(sum);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld    = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign rr_next            = (gnt_idx == PTR_W'(NUM_OUT_PORTS-1)) ? '0 : gnt_idx + 1'b1;
  assign ack_interface2user = ~full_p0 | grant;
  assign capture            = vld_user2interface & ack_interface2user;

  // Stage p0: per-port holding words
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (capture[i])
        hold_p0[i] <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_p0 <= '0;
      rr_ptr  <= '0;
      pkt_p1  <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        seq[i]    <= '0;
        credit[i] <= CREDIT_BITS'(CREDIT_INIT);
        dest[i]   <= {NUM_LEAF_BITS'(0), NUM_PORT_BITS'(i+1)};
      end
    end else begin
      // Stage p1: registered packet toward the BFT
      if (gnt_vld) begin
        rr_ptr <= rr_next;
        pkt_p1 <= {1'b1, dest[gnt_idx], seq[gnt_idx], hold_p0[gnt_idx]};
      end else begin
        pkt_p1 <= '0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (capture[i])
          full_p0[i] <= 1'b1;
        else if (grant[i])
          full_p0[i] <= 1'b0;
        if (grant[i])
          seq[i] <= seq[i] + 1'b1;
        if (!resend) begin
          if (grant[i] && !credit_ret[i])
            credit[i] <= credit[i] - 1'b1;
          else if (credit_ret[i] && !grant[i] && credit[i] < CREDIT_BITS'(CREDIT_INIT))
            credit[i] <= credit[i] + 1'b1;
        end
        // A same-cycle grant has already sampled the old entry above.
        if (cfg_we && cfg_sel == NUM_PORT_BITS'(i))
          dest[i] <= cfg_dest;
      end
    end
  end

  assign dout_leaf_interface2bft = resend ? '0 : pkt_p1;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Randomised bench for leaf_out_packetizer with a queue-based scoreboard fed by
// a port-level reference model.
module tb_leaf_out_packetizer;
  localparam int N  = 6;
  localparam int PB = 32;
  localparam int CI = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N*PB-1:0]   din;
  logic [N-1:0]      vld;
  logic [N-1:0]      ack;
  logic              cfg_we;
  logic [3:0]        cfg_sel;
  logic [8:0]        cfg_dest;
  logic [N-1:0]      credit_ret;
  logic              resend;
  logic [48:0]       dout;

  always #5 clk = ~clk;

  leaf_out_packetizer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_we                  (cfg_we),
    .cfg_sel                 (cfg_sel),
    .cfg_dest                (cfg_dest),
    .credit_ret              (credit_ret),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  int checks = 0;
  int errors = 0;
  logic [48:0] exp_q[$];
  logic        rand_din = 1'b1;

  // Reference model: per-port word slot, sequence, credits and destination.
  logic        m_full [N];
  logic [31:0] m_word [N];
  int          m_seq  [N];
  int          m_cred [N];
  logic [8:0]  m_dest [N];
  int          m_rr;
  logic [48:0] m_pend;
  logic        m_pend_vld;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_seq[i]  = 0;
      m_cred[i] = CI;
      m_dest[i] = {5'd0, 4'(i+1)};
    end
    m_rr       = 0;
    m_pend_vld = 1'b0;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] ret, input logic rs,
                      input logic we, input logic [3:0] sel, input logic [8:0] dst);
    int g;
    logic [N-1:0] ea;
    @(negedge clk);
    vld = v; credit_ret = ret; resend = rs;
    cfg_we = we; cfg_sel = sel; cfg_dest = dst;
    if (rand_din)
      for (int i = 0; i < N; i++) din[i*PB +: PB] = $urandom;
    #1;
    if (m_pend_vld && !rs) exp_q.push_back(m_pend);
    m_pend_vld = 1'b0;
    g = -1;
    if (!rs)
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (g < 0 && m_full[p] && m_cred[p] > 0) g = p;
      end
    for (int i = 0; i < N; i++) ea[i] = !m_full[i] || (g == i);
    chk("ack", 64'(ack), 64'(ea));
    if (g >= 0) begin
      m_pend     = {1'b1, m_dest[g], 7'(m_seq[g]), m_word[g]};
      m_pend_vld = 1'b1;
      m_seq[g]   = (m_seq[g] + 1) % 128;
      m_rr       = (g + 1) % N;
    end
    if (!rs)
      for (int i = 0; i < N; i++) begin
        if (g == i && !ret[i]) m_cred[i]--;
        else if (ret[i] && g != i && m_cred[i] < CI) m_cred[i]++;
      end
    for (int i = 0; i < N; i++) begin
      if (v[i] && ea[i]) begin
        m_word[i] = din[i*PB +: PB];
        m_full[i] = 1'b1;
      end else if (g == i) begin
        m_full[i] = 1'b0;
      end
    end
    if (we && sel < N) m_dest[sel] = dst;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step('0, '0, 1'b0, 1'b0, 4'd0, 9'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld = '0; credit_ret = '0; resend = 1'b0; cfg_we = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #3;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ack", 64'(ack), 64'h3f);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    logic [48:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (dout !== '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt got %h want none", dout);
        end else begin
          e = exp_q.pop_front();
          chk("pkt", 64'(dout), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; din = '0; vld = '0; credit_ret = '0; resend = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_dest = '0;
    model_reset();
    do_reset();

    // Single word, fixed payload, observed two cycles after acceptance
    rand_din = 1'b0;
    din[31:0] = 32'hDEADBEEF;
    step(6'b000001, '0, 1'b0, 1'b0, 4'd0, 9'd0);
    idle(2);
    #2;
    chk("first_pkt", 64'(dout), 64'({1'b1, 5'd0, 4'd1, 7'd0, 32'hDEADBEEF}));
    idle(1);
    #2;
    chk("first_idle", 64'(dout), 64'd0);
    rand_din = 1'b1;

    // All ports streaming, then reset while words are still held
    for (int c = 0; c < 30; c++) step('1, '0, 1'b0, 1'b0, 4'd0, 9'd0);
    do_reset();

    // Port 2 exhausts its credits, then one credit releases the held word
    for (int c = 0; c < 70; c++) step(6'b000100, '0, 1'b0, 1'b0, 4'd0, 9'd0);
    chk("p2_blocked_ack", 64'(ack[2]), 64'd0);
    step('0, 6'b000100, 1'b0, 1'b0, 4'd0, 9'd0);
    idle(4);

    // Port 0 with credits returned every cycle, sequence wraps
    for (int c = 0; c < 130; c++) step(6'b000001, 6'b000001, 1'b0, 1'b0, 4'd0, 9'd0);
    for (int c = 0; c < 4; c++) step('0, 6'b000001, 1'b0, 1'b0, 4'd0, 9'd0);
    idle(3);

    // Resend held high while ports 1 and 3 are full
    step(6'b001010, '0, 1'b1, 1'b0, 4'd0, 9'd0);
    for (int c = 0; c < 10; c++) step('0, '0, 1'b1, 1'b0, 4'd0, 9'd0);
    idle(5);

    // Destination table write, out-of-range write, then a word on port 4
    step('0, '0, 1'b0, 1'b1, 4'd4, {5'd17, 4'd9});
    step('0, '0, 1'b0, 1'b1, 4'd12, 9'h1ff);
    step(6'b010000, '0, 1'b0, 1'b0, 4'd0, 9'd0);
    idle(2);
    #2;
    chk("cfg_dest_field", 64'(dout[47:39]), 64'({5'd17, 4'd9}));
    idle(3);

    // Random traffic
    for (int c = 0; c < 2000; c++)
      step(N'($urandom), ($urandom % 4 == 0) ? N'($urandom) : '0,
           ($urandom % 16 == 0), ($urandom % 32 == 0), 4'($urandom), 9'($urandom));
    idle(12);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
